ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised, multi-cycle control sequencer that replaces the single-cycle opcode decoder in the processor core. It sits between instruction fetch and the datapath. It decodes the opcode into the standard control set. It also holds the datapath for instructions that need more than one cycle: IN waits on the input device, HD Read/Write waits on the disk, and KERNEL_SWAP runs a multi-beat context store. A registered `pc_en` tells fetch when to advance.

## Interface
- `OPW`, 6: opcode width; opcodes listed below are zero-extended to `OPW`.
- `ALUW`, 6: `OpALU` width; always driven to zero.
- `SWAP_BEATS`, 4: length of KERNEL_SWAP, in cycles (≥1).
- `HD_TIMEOUT`, 255: maximum wait cycles for `hd_ready` (≥1).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Opcode` in OPW: opcode of the current instruction.
- `instr_valid` in 1: `Opcode` is valid this cycle.
- `in_valid` in 1: input device has data (level).
- `hd_ready` in 1: disk transfer done (level).
- `resume` in 1: leave HALTED.
- `OpIO, MemRead, MemWrite, RegWrite, AluSrc, RegDst, Desvio, TypeJR, WriteHD, Syscall_Sign, PID_wr, Halt` out 1: registered controls.
- `Mem2Reg` out 2: writeback select (00 mem, 01 IO, 10 ALU, 11 HD).
- `OpALU` out ALUW: always 0.
- `pc_en` out 1: one-cycle pulse; fetch advances.
- `swap_beat` out clog2(SWAP_BEATS) (min 1): beat index during SWAP.
- `busy` out 1: high in any state other than DECODE.
- `hd_error` out 1: sticky flag, set on HD timeout.

## Operation
- Reset values: all 1-bit controls 0, `Mem2Reg`=10, `OpALU`=0, `pc_en`=0, `swap_beat`=0, `hd_error`=0, state DECODE.
- Decode table (unlisted opcodes = NOP: all controls 0, `Mem2Reg`=10):
  - R-type, opcodes 0, 1, 4, 13, 15, 16, 17, 18: `RegDst`=1, `RegWrite`=1.
  - ADDI 2, MOVE 3, SUBI 20: `RegWrite`=1, `AluSrc`=1.
  - Jump 5: `RegDst`=1, `AluSrc`=1, `Desvio`=1.
  - JR 19: as Jump, plus `TypeJR`=1.
  - BEQ 10, BNE 11: `Desvio`=1.
  - Load 6: `RegWrite`=1, `AluSrc`=1, `MemRead`=1, `Mem2Reg`=00.
  - SET_PID 28: as Load, plus `PID_wr`=1.
  - Store 7: `AluSrc`=1, `MemWrite`=1.
  - OUT 9: `OpIO`=1, `AluSrc`=1, `Mem2Reg`=01.
  - IN 8: `OpIO`=1, `AluSrc`=1, `Mem2Reg`=01, `RegWrite` only when granted.
  - Write 30: `AluSrc`=1, `Mem2Reg`=11, `WriteHD`=1, `RegWrite` only when granted.
  - Read 31: as Write, but `MemRead`=1 instead of `WriteHD`.
  - KERNEL_SWAP 33: `AluSrc`=1, `MemWrite`=1, `Syscall_Sign`=1.
  - HALT 25: see HALTED.
- States:
  - DECODE: on `instr_valid`, register the decoded controls.
    - Single-cycle opcodes: `pc_en`=1 in the same registered cycle; stay in DECODE.
    - IN goes to WAIT_IN; Write/Read go to WAIT_HD; KERNEL_SWAP goes to SWAP; HALT goes to HALTED.
    - Without `instr_valid`, drive NOP controls and `pc_en`=0.
  - WAIT_IN: `Halt`=1, `OpIO`=1, `RegWrite`=0. On `in_valid`, the next cycle has `RegWrite`=1, `Halt`=0, `pc_en`=1, and the state returns to DECODE.
  - WAIT_HD: a wait counter starts at 0 and increments each cycle. On `hd_ready`, the next cycle has `RegWrite`=1 and `pc_en`=1, then DECODE. If the count reaches `HD_TIMEOUT` without `hd_ready`, set `hd_error`, pulse `pc_en` with `RegWrite`=0, and return to DECODE.
  - SWAP: `swap_beat` counts 0 to `SWAP_BEATS`-1, one beat per cycle, with `MemWrite`=1 and `Syscall_Sign`=1 on every beat. `pc_en`=1 on the last beat, then DECODE.
  - HALTED: all controls 0 except `Halt`=1; `pc_en`=0. On `resume`, the next cycle goes to DECODE with `pc_en`=1.
- `instr_valid` is ignored in every state except DECODE; `Opcode` is latched at decode.
- `hd_error` is cleared only by `reset`.

## Timing
- All outputs are registered. Controls appear one cycle after `instr_valid` is sampled.
- Cycles from issue to `pc_en`:
  - Single-cycle opcodes: 1.
  - IN: 1 plus the number of cycles until `in_valid`, plus 1.
  - SWAP: `SWAP_BEATS`.
  - HD timeout: `HD_TIMEOUT`+1.
- `hd_ready` or `in_valid` already high at entry: completion in the next cycle, giving a minimum latency of 2.
- `hd_ready` and timeout in the same cycle: `hd_ready` wins; no error.
- `reset` mid-operation: immediate return to reset values. An IN or SWAP in progress is abandoned with no `RegWrite`.
- `SWAP_BEATS`=1: the single beat also carries `pc_en`.

## Test plan
- Reset mid-SWAP at beat 2 → all outputs return to reset values asynchronously (`Mem2Reg`=10), and the next `instr_valid` decodes normally.
- Opcodes 0, 2, 6, 7, 9, 19 with `instr_valid` → control sets match the table, `pc_en` pulses once each, `busy`=0 throughout.
- IN with `in_valid` raised 5 cycles later → `Halt`=1 for 5 cycles, then one cycle with `RegWrite`=1, `Mem2Reg`=01, `pc_en`=1.
- Write with `HD_TIMEOUT`=8 and no `hd_ready` → `hd_error`=1, `pc_en` on cycle 9, `RegWrite` never 1. A following Read with `hd_ready` at cycle 3 → `RegWrite`=1, `Mem2Reg`=11.
- KERNEL_SWAP with `SWAP_BEATS`=4 → `swap_beat` 0,1,2,3; `MemWrite`/`Syscall_Sign` high for 4 cycles; `pc_en` on beat 3. `instr_valid` pulses during SWAP are ignored.
- HALT → `Halt` held for 20 cycles with `pc_en`=0; `resume` → `pc_en`=1 the next cycle, then DECODE.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: decodes opcodes into registered datapath controls
// and stalls fetch for IN, disk transfers, KERNEL_SWAP and HALT.
module ctrl_sequencer #(
    parameter int OPW        = 6,
    parameter int ALUW       = 6,
    parameter int SWAP_BEATS = 4,
    parameter int HD_TIMEOUT = 255,
    localparam int SBW       = (SWAP_BEATS > 1) ? $clog2(SWAP_BEATS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OPW-1:0]  Opcode,
    input  logic            instr_valid,
    input  logic            in_valid,
    input  logic            hd_ready,
    input  logic            resume,
    output logic            OpIO,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            AluSrc,
    output logic            RegDst,
    output logic            Desvio,
    output logic            TypeJR,
    output logic            WriteHD,
    output logic            Syscall_Sign,
    output logic            PID_wr,
    output logic            Halt,
    output logic [1:0]      Mem2Reg,
    output logic [ALUW-1:0] OpALU,
    output logic            pc_en,
    output logic [SBW-1:0]  swap_beat,
    output logic            busy,
    output logic            hd_error
);

    localparam int CNT_W = $clog2(HD_TIMEOUT + 1);

    localparam logic [2:0] S_DECODE  = 3'd0;
    localparam logic [2:0] S_WAIT_IN = 3'd1;
    localparam logic [2:0] S_WAIT_HD = 3'd2;
    localparam logic [2:0] S_SWAP    = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    localparam logic [OPW-1:0] OP_IN    = OPW'(8);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(25);
    localparam logic [OPW-1:0] OP_WRITE = OPW'(30);
    localparam logic [OPW-1:0] OP_READ  = OPW'(31);
    localparam logic [OPW-1:0] OP_KSWAP = OPW'(33);

    typedef struct packed {
        logic       opio;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       alusrc;
        logic       regdst;
        logic       desvio;
        logic       typejr;
        logic       writehd;
        logic       syscall;
        logic       pidwr;
        logic       halt;
        logic [1:0] mem2reg;
    } ctl_t;

    function automatic ctl_t nop_ctl();
        ctl_t c;
        c         = '0;
        c.mem2reg = 2'b10;
        return c;
    endfunction

    // Control set shown in the first cycle after issue; multi-cycle opcodes show their wait-state view.
    function automatic ctl_t decode(input logic [OPW-1:0] op);
        ctl_t c;
        c = nop_ctl();
        case (op)
            OPW'(0), OPW'(1), OPW'(4), OPW'(13),
            OPW'(15), OPW'(16), OPW'(17), OPW'(18): begin
                c.regdst = 1'b1; c.regwrite = 1'b1;
            end
            OPW'(2), OPW'(3), OPW'(20): begin
                c.regwrite = 1'b1; c.alusrc = 1'b1;
            end
            OPW'(5): begin
                c.regdst = 1'b1; c.alusrc = 1'b1; c.desvio = 1'b1;
            end
            OPW'(19): begin
                c.regdst = 1'b1; c.alusrc = 1'b1; c.desvio = 1'b1; c.typejr = 1'b1;
            end
            OPW'(10), OPW'(11): c.desvio = 1'b1;
            OPW'(6), OPW'(28): begin
                c.regwrite = 1'b1; c.alusrc = 1'b1; c.memread = 1'b1;
                c.mem2reg = 2'b00; c.pidwr = (op == OPW'(28));
            end
            OPW'(7): begin
                c.alusrc = 1'b1; c.memwrite = 1'b1;
            end
            OPW'(9): begin
                c.opio = 1'b1; c.alusrc = 1'b1; c.mem2reg = 2'b01;
            end
            OP_IN: begin
                c.opio = 1'b1; c.alusrc = 1'b1; c.mem2reg = 2'b01; c.halt = 1'b1;
            end
            OP_WRITE: begin
                c.alusrc = 1'b1; c.mem2reg = 2'b11; c.writehd = 1'b1;
            end
            OP_READ: begin
                c.alusrc = 1'b1; c.mem2reg = 2'b11; c.memread = 1'b1;
            end
            OP_KSWAP: begin
                c.alusrc = 1'b1; c.memwrite = 1'b1; c.syscall = 1'b1;
            end
            OP_HALT: c.halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    logic [2:0]       state_q, state_d;
    ctl_t             ctl_q, ctl_d;
    logic             pc_en_q, pc_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SBW-1:0]   beat_q, beat_d;
    logic             err_q, err_d;
    logic             busy_q;

    always_comb begin
        state_d = state_q;
        ctl_d   = nop_ctl();
        pc_en_d = 1'b0;
        cnt_d   = cnt_q;
        beat_d  = '0;
        err_d   = err_q;
        case (state_q)
            S_DECODE: begin
                if (instr_valid) begin
                    ctl_d = decode(Opcode);
                    case (Opcode)
                        OP_IN:             state_d = S_WAIT_IN;
                        OP_WRITE, OP_READ: begin
                            state_d = S_WAIT_HD;
                            cnt_d   = '0;
                        end
                        OP_KSWAP: begin
                            if (SWAP_BEATS == 1) pc_en_d = 1'b1;
                            else                 state_d = S_SWAP;
                        end
                        OP_HALT:           state_d = S_HALTED;
                        default:           pc_en_d = 1'b1;
                    endcase
                end
            end
            S_WAIT_IN: begin
                ctl_d = ctl_q;
                if (in_valid) begin
                    ctl_d.halt     = 1'b0;
                    ctl_d.regwrite = 1'b1;
                    pc_en_d        = 1'b1;
                    state_d        = S_DECODE;
                end
            end
            S_WAIT_HD: begin
                ctl_d = ctl_q;
                // A ready disk beats a timeout landing on the same cycle.
                if (hd_ready) begin
                    ctl_d.regwrite = 1'b1;
                    pc_en_d        = 1'b1;
                    state_d        = S_DECODE;
                end else if (cnt_q == CNT_W'(HD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    pc_en_d = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SWAP: begin
                ctl_d  = ctl_q;
                beat_d = beat_q + 1'b1;
                if (beat_d == SBW'(SWAP_BEATS - 1)) begin
                    pc_en_d = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_HALTED: begin
                ctl_d = ctl_q;
                if (resume) begin
                    ctl_d   = nop_ctl();
                    pc_en_d = 1'b1;
                    state_d = S_DECODE;
                end
            end
            default: state_d = S_DECODE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_DECODE;
            ctl_q   <= nop_ctl();
            pc_en_q <= 1'b0;
            cnt_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            pc_en_q <= pc_en_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_DECODE);
        end
    end

    assign OpIO         = ctl_q.opio;
    assign MemRead      = ctl_q.memread;
    assign MemWrite     = ctl_q.memwrite;
    assign RegWrite     = ctl_q.regwrite;
    assign AluSrc       = ctl_q.alusrc;
    assign RegDst       = ctl_q.regdst;
    assign Desvio       = ctl_q.desvio;
    assign TypeJR       = ctl_q.typejr;
    assign WriteHD      = ctl_q.writehd;
    assign Syscall_Sign = ctl_q.syscall;
    assign PID_wr       = ctl_q.pidwr;
    assign Halt         = ctl_q.halt;
    assign Mem2Reg      = ctl_q.mem2reg;
    assign OpALU        = '0;
    assign pc_en        = pc_en_q;
    assign swap_beat    = beat_q;
    assign busy         = busy_q;
    assign hd_error     = err_q;

endmodule
